counter_sweep_ctrl: RTL

Command-driven controller on the driving side of the up_down_counter interface. It generates load, up_down and input_load, and watches count_out and carry_out. It takes a sweep command (lo, hi, sweep count) over a valid/ready handshake and makes the counter ping-pong lo→hi→lo the requested number of times. Between commands it keeps the counter parked with a held load.

---
 rtl/counter_sweep_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_sweep_ctrl
// Purpose  : Command-driven sweep controller for an up/down counter. Accepts
//            a (lo, hi, sweeps) command and drives the counter lo->hi->lo the
//            requested number of times, keeping it parked with a held load
//            between commands.
// Revision : 1.0 - initial release
// ============================================================================
module counter_sweep_ctrl #(
    parameter int N  = 4,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_lo,
    input  logic [N-1:0]  cmd_hi,
    input  logic [SW-1:0] cmd_sweeps,
    input  logic          abort,
    input  logic [N-1:0]  count_out,
    input  logic          carry_out,
    output logic          load,
    output logic          up_down,
    output logic [N-1:0]  input_load,
    output logic          busy,
    output logic          done,
    output logic          cmd_err,
    output logic          fault
);

    localparam logic [2:0]    c_IDLE   = 3'd0;
    localparam logic [2:0]    c_LOAD   = 3'd1;
    localparam logic [2:0]    c_UP     = 3'd2;
    localparam logic [2:0]    c_DOWN   = 3'd3;
    localparam logic [2:0]    c_DONE   = 3'd4;

    localparam logic [N:0]    c_TWO_N1 = (N+1)'(2);
    localparam logic [N-1:0]  c_ONE_N  = N'(1);
    localparam logic [SW-1:0] c_ONE_SW = SW'(1);
    localparam logic [SW-1:0] c_ZERO_SW = '0;

    logic [2:0]    r_state;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_hi;
    logic [SW-1:0] r_sweeps;
    logic          r_load;
    logic          r_up_down;
    logic [N-1:0]  r_input_load;
    logic          r_done;
    logic          r_cmd_err;
    logic          r_fault;

    logic          w_reject;
    logic          w_accept;

    // A sweep needs at least two steps between bounds; the lo+2 sum is kept
    // in N+1 bits so lo near the top of the range cannot wrap and pass.
    assign w_reject = ({1'b0, cmd_hi} < ({1'b0, cmd_lo} + c_TWO_N1)) ||
                      (cmd_sweeps == c_ZERO_SW);
    assign w_accept = cmd_valid && (r_state == c_IDLE);

    assign cmd_ready  = (r_state == c_IDLE);
    assign busy       = (r_state != c_IDLE);
    assign load       = r_load;
    assign up_down    = r_up_down;
    assign input_load = r_input_load;
    assign done       = r_done;
    assign cmd_err    = r_cmd_err;
    assign fault      = r_fault;

    // Sweep state machine; all counter controls and status flags are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_sweeps     <= '0;
            r_load       <= 1'b1;
            r_up_down    <= 1'b1;
            r_input_load <= '0;
            r_done       <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_load <= 1'b1;
                    if (w_accept) begin
                        if (w_reject) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_lo         <= cmd_lo;
                            r_hi         <= cmd_hi;
                            r_sweeps     <= cmd_sweeps;
                            r_input_load <= cmd_lo;
                            r_fault      <= 1'b0;
                            r_state      <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    if (abort) begin
                        r_input_load <= count_out;
                        r_load       <= 1'b1;
                        r_state      <= c_IDLE;
                    end else begin
                        r_load    <= 1'b0;
                        r_up_down <= 1'b1;
                        r_state   <= c_UP;
                    end
                end
                c_UP: begin
                    if (carry_out) begin
                        r_fault      <= 1'b1;
                        r_input_load <= '0;
                        r_load       <= 1'b1;
                        r_state      <= c_IDLE;
                    end else if (abort) begin
                        r_input_load <= count_out;
                        r_load       <= 1'b1;
                        r_state      <= c_IDLE;
                    end else if (count_out == (r_hi - c_ONE_N)) begin
                        // Counter lands on hi at this edge; turn around next.
                        r_up_down <= 1'b0;
                        r_state   <= c_DOWN;
                    end
                end
                c_DOWN: begin
                    if (carry_out) begin
                        r_fault      <= 1'b1;
                        r_input_load <= '0;
                        r_load       <= 1'b1;
                        r_state      <= c_IDLE;
                    end else if (abort) begin
                        r_input_load <= count_out;
                        r_load       <= 1'b1;
                        r_state      <= c_IDLE;
                    end else if (count_out == (r_lo + c_ONE_N)) begin
                        // Counter lands on lo at this edge; input_load still
                        // holds lo, so raising load parks it there.
                        if (r_sweeps == c_ONE_SW) begin
                            r_load  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            r_sweeps  <= r_sweeps - c_ONE_SW;
                            r_up_down <= 1'b1;
                            r_state   <= c_UP;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_load  <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
